// File: rtl/rv32_div_unit_pkg.sv
// Shared types and helpers for the RV32M iterative divider.
package rv32_div_unit_pkg;

  localparam int unsigned RV32_DIV_ITERS = 32;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSll, AluSrl, AluSra,
    AluSlt, AluSltu, AluMul, AluDiv, AluDivu, AluRem, AluRemu
  } alu_op_t;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} rv32_div_state_t;

  typedef struct packed {
    alu_op_t     alu_op;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [4:0]  rd_sel;
    logic [4:0]  rs1_sel;
    logic [4:0]  rs2_sel;
    logic [31:0] pc;
    logic        valid_opcode;
    logic        dont_forward;
  } rv32_issue_packet_t;

  typedef struct packed {
    logic [31:0] wb_pc;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_enable;
    logic [4:0]  rs1_sel;
    logic [4:0]  rs2_sel;
    logic        valid_opcode;
    logic        dont_forward;
  } rv32_ex2mem_wb_packet_t;

  // hit: the result is fixed by the operands, not by the iterative datapath
  typedef struct packed {
    logic        hit;
    logic [31:0] value;
  } div_special_t;

  function automatic logic is_div_op(alu_op_t op);
    return op inside {AluDiv, AluDivu, AluRem, AluRemu};
  endfunction

  function automatic logic is_signed_op(alu_op_t op);
    return op inside {AluDiv, AluRem};
  endfunction

  function automatic logic is_rem_op(alu_op_t op);
    return op inside {AluRem, AluRemu};
  endfunction

  // Divide-by-zero, signed overflow and non-divide ops have closed-form results.
  function automatic div_special_t div_special(alu_op_t op, logic [31:0] a, logic [31:0] b);
    div_special_t s;
    s.hit   = 1'b0;
    s.value = '0;
    if (!is_div_op(op)) begin
      s.hit = 1'b1;
    end else if (b == '0) begin
      s.hit   = 1'b1;
      s.value = is_rem_op(op) ? a : '1;
    end else if (is_signed_op(op) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
      s.hit   = 1'b1;
      s.value = is_rem_op(op) ? 32'h0 : 32'h8000_0000;
    end
    return s;
  endfunction

  function automatic rv32_ex2mem_wb_packet_t make_wb(rv32_issue_packet_t p, logic [31:0] data);
    rv32_ex2mem_wb_packet_t w;
    w.wb_pc        = p.pc;
    w.wb_addr      = p.rd_sel;
    w.wb_data      = is_div_op(p.alu_op) ? data : '0;
    w.wb_enable    = (p.rd_sel != 5'd0) && p.valid_opcode && is_div_op(p.alu_op);
    w.rs1_sel      = p.rs1_sel;
    w.rs2_sel      = p.rs2_sel;
    w.valid_opcode = p.valid_opcode;
    w.dont_forward = p.dont_forward;
    return w;
  endfunction

endpackage

// File: rtl/rv32_div_unit_if.sv
// Issue-side and write-back-side handshakes of the divider.
// slave: the divider; master: the surrounding pipeline.
interface rv32_div_unit_if;
  import rv32_div_unit_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  rv32_issue_packet_t     in_pkt;
  logic                   out_valid;
  logic                   out_ready;
  rv32_ex2mem_wb_packet_t out_pkt;
  logic                   busy;

  modport slave (
    input  in_valid, in_pkt, out_ready,
    output in_ready, out_valid, out_pkt, busy
  );

  modport master (
    output in_valid, in_pkt, out_ready,
    input  in_ready, out_valid, out_pkt, busy
  );
endinterface

// File: rtl/rv32_div_step.sv
// One restoring-division step on a (Width+1)-bit partial remainder.
module rv32_div_step #(
  parameter int unsigned Width = 32
) (
  input  logic [Width:0]   rem_i,
  input  logic [Width-1:0] quo_i,
  input  logic [Width-1:0] div_i,
  output logic [Width:0]   rem_o,
  output logic [Width-1:0] quo_o
);
  logic [Width+1:0] trial;
  logic             ge;

  // Shift {rem, quo} left one bit and trial-subtract; one spare bit carries the sign.
  always_comb begin
    trial = {rem_i, quo_i[Width-1]} - {2'b00, div_i};
    ge    = ~trial[Width+1];
    rem_o = ge ? trial[Width:0] : {rem_i[Width-1:0], quo_i[Width-1]};
    quo_o = {quo_i[Width-2:0], ge};
  end
endmodule

// File: rtl/rv32_div_unit.sv
// Iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU).
// Optional macro RV32_DIV_EARLY_OUT_EN: special-case operations skip the
// 32 CALC cycles and complete one cycle after acceptance.
module rv32_div_unit
  import rv32_div_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic            clk,
  input logic            rst,
  input logic            flush,
  rv32_div_unit_if.slave bus
);
`ifdef RV32_DIV_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif
  localparam int unsigned CntW = $clog2(RV32_DIV_ITERS);

  rv32_div_state_t        state_q, state_d;
  logic [CntW-1:0]        cnt_q;
  logic [XLEN:0]          rem_q;
  logic [XLEN-1:0]        quo_q, div_q;
  logic                   neg_quo_q, neg_rem_q;
  rv32_issue_packet_t     pkt_q;
  logic                   out_valid_q;
  rv32_ex2mem_wb_packet_t out_pkt_q, out_pkt_d;

  logic                   accept, last_step, early_go, load_out;
  logic [XLEN:0]          step_rem;
  logic [XLEN-1:0]        step_quo;
  div_special_t           spec_in, spec_calc;
  logic                   in_neg_a, in_neg_b;
  logic [XLEN-1:0]        in_mag_a, in_mag_b;
  logic [XLEN-1:0]        q_fix, r_fix, calc_result;

  assign bus.in_ready  = (state_q == StIdle) && !rst;
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.out_pkt   = out_pkt_q;

  // Acceptance decode and operand magnitudes for signed ops.
  always_comb begin
    accept    = bus.in_valid && bus.in_ready && !flush;
    spec_in   = div_special(bus.in_pkt.alu_op, bus.in_pkt.rs1_value, bus.in_pkt.rs2_value);
    early_go  = EarlyOut && spec_in.hit;
    last_step = (cnt_q == CntW'(RV32_DIV_ITERS - 1));
    in_neg_a  = is_signed_op(bus.in_pkt.alu_op) && bus.in_pkt.rs1_value[XLEN-1];
    in_neg_b  = is_signed_op(bus.in_pkt.alu_op) && bus.in_pkt.rs2_value[XLEN-1];
    in_mag_a  = in_neg_a ? -bus.in_pkt.rs1_value : bus.in_pkt.rs1_value;
    in_mag_b  = in_neg_b ? -bus.in_pkt.rs2_value : bus.in_pkt.rs2_value;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = early_go ? StDone : StCalc;
      StCalc:  if (last_step) state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  rv32_div_step #(
    .Width(XLEN)
  ) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .div_i(div_q),
    .rem_o(step_rem),
    .quo_o(step_quo)
  );

  // Final result: sign fixups on the last step, then special-case override.
  always_comb begin
    q_fix       = neg_quo_q ? -step_quo : step_quo;
    r_fix       = neg_rem_q ? -step_rem[XLEN-1:0] : step_rem[XLEN-1:0];
    spec_calc   = div_special(pkt_q.alu_op, pkt_q.rs1_value, pkt_q.rs2_value);
    calc_result = spec_calc.hit ? spec_calc.value
                                : (is_rem_op(pkt_q.alu_op) ? r_fix : q_fix);
    // Only an early-out entry comes straight from idle.
    out_pkt_d   = (state_q == StIdle) ? make_wb(bus.in_pkt, spec_in.value)
                                      : make_wb(pkt_q, calc_result);
    load_out    = (state_d == StDone) && (state_q != StDone);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Operand latch and iterative datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
    end else if (accept) begin
      pkt_q     <= bus.in_pkt;
      rem_q     <= '0;
      quo_q     <= in_mag_a;
      div_q     <= in_mag_b;
      neg_quo_q <= in_neg_a ^ in_neg_b;
      neg_rem_q <= in_neg_a;
      cnt_q     <= '0;
    end else if (state_q == StCalc) begin
      rem_q     <= step_rem;
      quo_q     <= step_quo;
      cnt_q     <= cnt_q + 1'b1;
    end
  end

  // Registered result; held stable while waiting for out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_pkt_q   <= '0;
    end else begin
      out_valid_q <= (state_d == StDone);
      if (load_out) out_pkt_q <= out_pkt_d;
    end
  end

endmodule

// File: tb/tb_rv32_div_unit.sv
// Self-checking bench for rv32_div_unit: directed cases, flush, back-pressure
// and randomized operations against an arithmetic reference model.
module tb_rv32_div_unit;
  import rv32_div_unit_pkg::*;

`ifdef RV32_DIV_EARLY_OUT_EN
  localparam bit TbEarly = 1'b1;
`else
  localparam bit TbEarly = 1'b0;
`endif

  logic clk;
  logic rst;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  rv32_div_unit_if bus();

  rv32_div_unit #(
    .XLEN(32)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics from plain arithmetic.
  function automatic logic [31:0] ref_result(alu_op_t op, logic [31:0] a, logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      AluDivu: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      AluRemu: return (b == 0) ? a : a % b;
      AluDiv:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000
                      : 32'($signed(a) / $signed(b));
      AluRem:  return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_latency(alu_op_t op, logic [31:0] a, logic [31:0] b);
    logic is_div, special;
    is_div  = (op == AluDiv) || (op == AluDivu) || (op == AluRem) || (op == AluRemu);
    special = !is_div || (b == 0) ||
              (((op == AluDiv) || (op == AluRem)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (TbEarly && special) ? 1 : 33;
  endfunction

  // Present a packet and return just after its acceptance edge.
  task automatic issue(input rv32_issue_packet_t p);
    int guard = 0;
    bus.in_pkt   = p;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("issue_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Cycles counted from the acceptance edge (1 = valid right after it).
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input alu_op_t op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    rv32_issue_packet_t p;
    int                 lat;
    logic               exp_en;
    p              = '0;
    p.alu_op       = op;
    p.rs1_value    = a;
    p.rs2_value    = b;
    p.rd_sel       = rd;
    p.rs1_sel      = 5'($urandom);
    p.rs2_sel      = 5'($urandom);
    p.pc           = $urandom & 32'hFFFF_FFFC;
    p.valid_opcode = 1'b1;
    p.dont_forward = 1'($urandom);
    exp_en = (rd != 0) && ((op == AluDiv) || (op == AluDivu) || (op == AluRem) || (op == AluRemu));
    issue(p);
    wait_valid(lat);
    check({tag, "_lat"}, 32'(lat), 32'(ref_latency(op, a, b)));
    check({tag, "_data"}, bus.out_pkt.wb_data, ref_result(op, a, b));
    check({tag, "_en"}, 32'(bus.out_pkt.wb_enable), 32'(exp_en));
    check({tag, "_addr"}, 32'(bus.out_pkt.wb_addr), 32'(rd));
    check({tag, "_pc"}, bus.out_pkt.wb_pc, p.pc);
    check({tag, "_meta"},
          32'({bus.out_pkt.rs1_sel, bus.out_pkt.rs2_sel, bus.out_pkt.valid_opcode,
               bus.out_pkt.dont_forward}),
          32'({p.rs1_sel, p.rs2_sel, p.valid_opcode, p.dont_forward}));
    @(posedge clk); #1;
    check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rv32_issue_packet_t     p;
    rv32_ex2mem_wb_packet_t snap;
    alu_op_t                ops[5];
    int                     lat;
    int                     seen;

    ops = '{AluDiv, AluDivu, AluRem, AluRemu, AluAdd};
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_pkt = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_out_pkt_zero", 32'(bus.out_pkt == '0), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed cases
    do_op("divu_100_7", AluDivu, 32'd100, 32'd7, 5'd5);
    do_op("remu_100_7", AluRemu, 32'd100, 32'd7, 5'd5);
    do_op("div_m7_2", AluDiv, 32'hFFFF_FFF9, 32'd2, 5'd3);
    do_op("rem_m7_2", AluRem, 32'hFFFF_FFF9, 32'd2, 5'd3);
    do_op("div_5_0", AluDiv, 32'd5, 32'd0, 5'd7);
    do_op("rem_5_0", AluRem, 32'd5, 32'd0, 5'd7);
    do_op("div_ovf", AluDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    do_op("rem_ovf", AluRem, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    do_op("divu_rd0", AluDivu, 32'd8, 32'd2, 5'd0);
    do_op("non_div", AluAdd, 32'd8, 32'd2, 5'd4);

    // Flush mid-calculation
    p = '0;
    p.alu_op = AluDivu;
    p.rs1_value = 32'd1000;
    p.rs2_value = 32'd3;
    p.rd_sel = 5'd2;
    p.valid_opcode = 1'b1;
    issue(p);
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("pre_flush_busy", 32'(bus.busy), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    check("flush_busy", 32'(bus.busy), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("flush_no_valid", 32'(seen), 32'd0);

    // in_valid together with flush in idle must not be taken
    bus.in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    flush = 1'b0;
    check("flush_blocks_accept", 32'(bus.busy), 32'd0);
    do_op("divu_9_3", AluDivu, 32'd9, 32'd3, 5'd6);

    // Back-pressure in DONE
    bus.out_ready = 1'b0;
    p = '0;
    p.alu_op = AluDiv;
    p.rs1_value = 32'hFFFF_FF9C;
    p.rs2_value = 32'd7;
    p.rd_sel = 5'd11;
    p.valid_opcode = 1'b1;
    issue(p);
    wait_valid(lat);
    check("bp_lat", 32'(lat), 32'd33);
    check("bp_data", bus.out_pkt.wb_data, ref_result(AluDiv, 32'hFFFF_FF9C, 32'd7));
    snap = bus.out_pkt;
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.out_valid && bus.out_pkt === snap && !bus.in_ready) seen++;
    end
    check("bp_hold_cycles", 32'(seen), 32'd5);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      do_op($sformatf("rnd%0d", i), ops[$urandom_range(0, 4)], rand_operand(), rand_operand(),
            5'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rv32_div_unit.md
# rv32_div_unit

Iterative 32-cycle radix-2 divider for the RV32M DIV/DIVU/REM/REMU operations in the InOrderSingleIssue execute stage. It takes an `rv32_issue_packet_t` from the issue stage with operands already resolved. It returns an `rv32_ex2mem_wb_packet_t` toward the memory stage. Valid/ready handshakes on both sides let the pipeline stall while a divide is in flight.

## Interface
- `XLEN`, default 32: operand width. Only 32 is supported.
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `flush`  input  1  kills any in-flight operation (branch redirect)
- `in_valid`  input  1  issue packet valid
- `in_ready`  output  1  unit can accept a packet this cycle
- `in_pkt`  input  `rv32_issue_packet_t`  operation, rs1_value/rs2_value, rd_sel, pc, metadata
- `out_valid`  output  1  result packet valid
- `out_ready`  input  1  downstream accepts the result
- `out_pkt`  output  `rv32_ex2mem_wb_packet_t`  write-back packet
- `busy`  output  1  state is not IDLE (hazard/stall input to issue)

## Operation
- States: IDLE, CALC, DONE.
- `in_ready = (state == IDLE) && !rst`. A packet is accepted on `in_valid && in_ready`.
- On acceptance, latch the packet and count = 0.
  - Signed ops (DIV, REM): dividend and divisor are converted to magnitudes. Record the quotient sign as sign(rs1) XOR sign(rs2) and the remainder sign as sign(rs1).
  - Unsigned ops (DIVU, REMU): operands are used as-is.
- CALC: one restoring step per cycle on a 33-bit partial remainder.
  - Shift {rem, quo} left by 1 and trial-subtract the divisor.
  - If the result is non-negative, commit it and set the quotient LSB to 1; otherwise set it to 0.
  - After 32 steps (count == 31), go to DONE.
- Entering DONE: apply the sign fixups (two's-complement negate where the recorded sign is 1), then select quotient (DIV/DIVU) or remainder (REM/REMU).
- Special cases always produce the RISC-V results:
  - Divisor 0: quotient 0xFFFFFFFF; remainder = rs1.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000; remainder 0.
- Non-divide `alu_op` accepted: retired through DONE with `wb_enable` = 0 and `wb_data` = 0.
- Output packet fields:
  - `wb_addr` = rd_sel; `wb_data` = result.
  - `wb_enable` = (rd_sel != 0) && valid_opcode.
  - `wb_pc`, `rs1_sel`, `rs2_sel`, `valid_opcode`, `dont_forward` copied from the latched packet.
- DONE holds `out_valid` and `out_pkt` stable until `out_ready`, then returns to IDLE.
- Flush: in any state, the next state is IDLE and `out_valid` is 0 the following cycle. A flush in DONE that coincides with `out_ready` still counts as a completed handoff. `in_valid` together with `flush` in IDLE is not accepted.
- Reset: state IDLE, `out_valid` 0, `out_pkt` all zeros, `busy` 0, counter 0.

## Timing
- Acceptance edge at cycle T; CALC occupies T+1..T+32; `out_valid` is high from cycle T+33.
- Early-out path (see Configuration): `out_valid` is high at T+1.
- No back-to-back overlap: `in_ready` is low from T+1 until the cycle after the DONE handshake.
- `out_valid` and `out_pkt` are registered, with no combinational path from input to output. `in_ready` depends only on state and `rst`.

## Configuration
- `RV32_DIV_EARLY_OUT_EN` defined:
  - Divide-by-zero, signed overflow and non-divide ops go IDLE→DONE directly, with the result computed combinationally at acceptance.
  - Latency for these cases is 1 cycle.
- Undefined:
  - Every accepted packet runs all 32 CALC cycles.
  - Special-case results override the datapath value when entering DONE.
  - Results are identical; only latency differs.

## Structure
- Add to `rv32_pkg`:
  - `rv32_div_state_t` enum {IDLE, CALC, DONE};
  - localparam `RV32_DIV_ITERS` = 32;
  - a function `is_div_op(alu_op_t)` returning 1 for DIV/DIVU/REM/REMU.
- One sub-module, `rv32_div_step`: combinational single restoring step. Inputs: 33-bit remainder, 32-bit quotient, 32-bit divisor. Outputs: next remainder and next quotient.
- The top level holds the FSM, counter, sign logic and output register.

## Test plan
- DIVU rs1 = 100, rs2 = 7, rd = 5 → at T+33: `wb_data` 14, `wb_addr` 5, `wb_enable` 1; the same operands with REMU → 2.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
- DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
  - With `RV32_DIV_EARLY_OUT_EN`: `out_valid` at T+1.
  - Without it: `out_valid` at T+33.
- Assert `flush` at T+10 → `out_valid` never rises, `in_ready` is 1 at T+11, and a new DIVU 9/3 returns 3.
- Hold `out_ready` low for 5 cycles in DONE → `out_pkt` is stable and `in_ready` stays 0. Raising `out_ready` gives one handshake, then IDLE.
- rd = 0 with DIVU 8/2 → `wb_data` 4, `wb_enable` 0.
